// File: rtl/pc_gen_ras_if.sv
// Front-end control bundle between the issue logic (master) and the PC generator (slave).
// Carries next-PC selection inputs plus registered PC, RAS status, trap and trace event outputs.
interface pc_gen_ras_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 8
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic            stall;
    logic [1:0]      jump;
    logic            br_taken;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] alu_result;
    logic [4:0]      rd;
    logic [4:0]      rs1;

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   ras_count;
    logic            misalign;
    logic [XLEN-1:0] misalign_addr;
    logic            call_evt;
    logic            ret_evt;
    logic            ret_hit;
    logic            ras_underflow;
    logic [XLEN-1:0] evt_pc;
    logic [XLEN-1:0] evt_target;

    modport master (
        output stall, jump, br_taken, imm, alu_result, rd, rs1,
        input  pc, ras_count, misalign, misalign_addr, call_evt, ret_evt,
               ret_hit, ras_underflow, evt_pc, evt_target
    );

    modport slave (
        input  stall, jump, br_taken, imm, alu_result, rd, rs1,
        output pc, ras_count, misalign, misalign_addr, call_evt, ret_evt,
               ret_hit, ras_underflow, evt_pc, evt_target
    );
endinterface

// File: rtl/pc_gen_ras.sv
// Next-PC generator with circular return-address stack and registered call/return trace events.
// Latency 1 cycle from inputs to pc/events; stall freezes all state and suppresses every pulse.
module pc_gen_ras #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000,
    parameter int              RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    pc_gen_ras_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        J_SEQ  = 2'b00,
        J_JAL  = 2'b01,
        J_JALR = 2'b10,
        J_BR   = 2'b11
    } jump_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } evt_t;

    logic [XLEN-1:0] pc_q;
    logic [PW-1:0]   ptr_q;
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];

    logic            misalign_q;
    logic [XLEN-1:0] misalign_addr_q;
    logic            call_q;
    logic            ret_q;
    logic            hit_q;
    logic            under_q;
    evt_t            evt_q;

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] rel_pc;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] ras_top;
    logic [PW-1:0]   top_ptr;
    logic            taken;
    logic            misaligned;
    logic            is_call;
    logic            is_ret;
    logic            do_push;
    logic            do_ret;
    logic            ras_full;
    jump_e           jsel;

    always_comb begin
        jsel    = jump_e'(bus.jump);
        seq_pc  = pc_q + XLEN'(4);
        rel_pc  = pc_q + bus.imm;
        target  = seq_pc;
        taken   = 1'b0;
        case (jsel)
            J_SEQ:  begin target = seq_pc;                         taken = 1'b0;         end
            J_JAL:  begin target = rel_pc;                         taken = 1'b1;         end
            J_JALR: begin target = bus.alu_result & ~XLEN'(1);     taken = 1'b1;         end
            J_BR:   begin target = bus.br_taken ? rel_pc : seq_pc; taken = bus.br_taken; end
            default: begin target = seq_pc;                        taken = 1'b0;         end
        endcase
        misaligned = taken && (target[1:0] != 2'b00);

        // rd==1 takes priority, so a JALR with rd==1 and rs1==1 is only a call
        is_call  = ((jsel == J_JAL) || (jsel == J_JALR)) && (bus.rd == 5'd1);
        is_ret   = (jsel == J_JALR) && (bus.rd == 5'd0) && (bus.rs1 == 5'd1);
        do_push  = !bus.stall && !misaligned && is_call;
        do_ret   = !bus.stall && !misaligned && is_ret;

        top_ptr  = ptr_q - PW'(1);
        ras_top  = ras_mem[top_ptr];
        ras_full = (count_q == CW'(RAS_DEPTH));
    end

    // Entries carry no reset; validity is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[ptr_q] <= seq_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q            <= RESET_PC;
            ptr_q           <= '0;
            count_q         <= '0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
            call_q          <= 1'b0;
            ret_q           <= 1'b0;
            hit_q           <= 1'b0;
            under_q         <= 1'b0;
            evt_q           <= '0;
        end else begin
            misalign_q <= 1'b0;
            call_q     <= 1'b0;
            ret_q      <= 1'b0;
            hit_q      <= 1'b0;
            under_q    <= 1'b0;
            if (!bus.stall) begin
                if (misaligned) begin
                    misalign_q      <= 1'b1;
                    misalign_addr_q <= target;
                end else begin
                    pc_q <= target;
                    if (do_push) begin
                        // A full stack wraps and silently overwrites its oldest entry.
                        ptr_q  <= ptr_q + PW'(1);
                        call_q <= 1'b1;
                        evt_q  <= '{pc: pc_q, target: target};
                        if (!ras_full) begin
                            count_q <= count_q + CW'(1);
                        end
                    end else if (do_ret) begin
                        ret_q <= 1'b1;
                        evt_q <= '{pc: pc_q, target: target};
                        if (count_q != '0) begin
                            ptr_q   <= top_ptr;
                            count_q <= count_q - CW'(1);
                            hit_q   <= (ras_top == target);
                        end else begin
                            under_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.pc            = pc_q;
    assign bus.ras_count     = count_q;
    assign bus.misalign      = misalign_q;
    assign bus.misalign_addr = misalign_addr_q;
    assign bus.call_evt      = call_q;
    assign bus.ret_evt       = ret_q;
    assign bus.ret_hit       = hit_q;
    assign bus.ras_underflow = under_q;
    assign bus.evt_pc        = evt_q.pc;
    assign bus.evt_target    = evt_q.target;
endmodule

// File: tb/tb_pc_gen_ras.sv
// Bench for pc_gen_ras: directed scenarios plus randomized traffic against a queue-based reference.
module tb_pc_gen_ras;
    localparam int          XLEN      = 32;
    localparam int          DEPTH     = 8;
    localparam logic [31:0] RESET_PC  = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pc_gen_ras_if #(.XLEN(XLEN), .RAS_DEPTH(DEPTH)) ifc ();

    pc_gen_ras #(.XLEN(XLEN), .RESET_PC(RESET_PC), .RAS_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    int vec  = 0;
    int errs = 0;

    // Reference state: architectural PC and the return stack as a queue (back = top).
    logic [31:0] m_pc;
    logic [31:0] m_ras [$];
    logic        e_misalign, e_call, e_ret, e_hit, e_under;
    logic [31:0] e_misaddr, e_evt_pc, e_evt_tgt;

    task automatic model_reset();
        m_pc = RESET_PC;
        m_ras.delete();
        e_misalign = 0; e_call = 0; e_ret = 0; e_hit = 0; e_under = 0;
        e_misaddr = 0; e_evt_pc = 0; e_evt_tgt = 0;
    endtask

    task automatic model_step(input logic s, input logic [1:0] j, input logic bt,
                              input logic [31:0] im, input logic [31:0] alu,
                              input logic [4:0] d, input logic [4:0] r1);
        logic [31:0] tgt;
        logic [31:0] top;
        bit tk, is_call, is_ret;
        e_misalign = 0; e_call = 0; e_ret = 0; e_hit = 0; e_under = 0;
        if (s) return;
        case (j)
            2'd0: tgt = m_pc + 4;
            2'd1: tgt = m_pc + im;
            2'd2: tgt = {alu[31:1], 1'b0};
            default: tgt = bt ? m_pc + im : m_pc + 4;
        endcase
        tk = (j == 2'd1) || (j == 2'd2) || (j == 2'd3 && bt);
        if (tk && tgt[1:0] != 2'b00) begin
            e_misalign = 1;
            e_misaddr  = tgt;
            return;
        end
        is_call = (j == 2'd1 || j == 2'd2) && d == 5'd1;
        is_ret  = (j == 2'd2) && d == 5'd0 && r1 == 5'd1;
        if (is_call) begin
            m_ras.push_back(m_pc + 4);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            e_call = 1; e_evt_pc = m_pc; e_evt_tgt = tgt;
        end else if (is_ret) begin
            e_ret = 1; e_evt_pc = m_pc; e_evt_tgt = tgt;
            if (m_ras.size() > 0) begin
                top   = m_ras.pop_back();
                e_hit = (top == tgt);
            end else begin
                e_under = 1;
            end
        end
        m_pc = tgt;
    endtask

    task automatic apply(input logic s, input logic [1:0] j, input logic bt,
                         input logic [31:0] im, input logic [31:0] alu,
                         input logic [4:0] d, input logic [4:0] r1);
        ifc.stall = s; ifc.jump = j; ifc.br_taken = bt; ifc.imm = im;
        ifc.alu_result = alu; ifc.rd = d; ifc.rs1 = r1;
        model_step(s, j, bt, im, alu, d, r1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        ifc.stall = 0; ifc.jump = 2'd1; ifc.br_taken = 1; ifc.imm = 32'h40;
        ifc.alu_result = 32'h1234; ifc.rd = 5'd1; ifc.rs1 = 5'd1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        vec++; if (ifc.pc !== 32'h8000_0000) begin errs++; $display("FAIL reset_pc got %h exp %h", ifc.pc, 32'h8000_0000); end
        vec++; if (ifc.ras_count !== 4'd0) begin errs++; $display("FAIL reset_count got %0d exp 0", ifc.ras_count); end
        vec++; if ({ifc.call_evt, ifc.ret_evt, ifc.misalign, ifc.ret_hit, ifc.ras_underflow} !== 5'b0) begin
            errs++; $display("FAIL reset_pulses got %b exp 00000",
                             {ifc.call_evt, ifc.ret_evt, ifc.misalign, ifc.ret_hit, ifc.ras_underflow}); end
        vec++; if ({ifc.evt_pc, ifc.evt_target, ifc.misalign_addr} !== 96'd0) begin
            errs++; $display("FAIL reset_regs got %h/%h/%h exp 0", ifc.evt_pc, ifc.evt_target, ifc.misalign_addr); end
    endtask

    task automatic test_seq();
        logic [31:0] exp_pc;
        for (int i = 1; i <= 4; i++) begin
            apply(0, 2'd0, 0, 32'h0, 32'h0, 5'd5, 5'd6);
            exp_pc = RESET_PC + 32'(4 * i);
            vec++; if (ifc.pc !== exp_pc) begin errs++; $display("FAIL seq_pc got %h exp %h", ifc.pc, exp_pc); end
            vec++; if (ifc.ras_count !== 4'd0) begin errs++; $display("FAIL seq_count got %0d exp 0", ifc.ras_count); end
        end
    endtask

    task automatic test_call_ret();
        apply(0, 2'd1, 0, 32'h100, 32'h0, 5'd1, 5'd0);
        vec++; if (ifc.pc !== 32'h8000_0110) begin errs++; $display("FAIL call_pc got %h exp 80000110", ifc.pc); end
        vec++; if (ifc.call_evt !== 1'b1 || ifc.ret_evt !== 1'b0) begin errs++; $display("FAIL call_evt got %b/%b exp 1/0", ifc.call_evt, ifc.ret_evt); end
        vec++; if (ifc.evt_pc !== 32'h8000_0010 || ifc.evt_target !== 32'h8000_0110) begin
            errs++; $display("FAIL call_trace got %h/%h exp 80000010/80000110", ifc.evt_pc, ifc.evt_target); end
        vec++; if (ifc.ras_count !== 4'd1) begin errs++; $display("FAIL call_count got %0d exp 1", ifc.ras_count); end
        apply(0, 2'd2, 0, 32'h0, 32'h8000_0014, 5'd0, 5'd1);
        vec++; if (ifc.pc !== 32'h8000_0014) begin errs++; $display("FAIL ret_pc got %h exp 80000014", ifc.pc); end
        vec++; if (ifc.ret_evt !== 1'b1 || ifc.ret_hit !== 1'b1 || ifc.call_evt !== 1'b0) begin
            errs++; $display("FAIL ret_evt got ret=%b hit=%b call=%b exp 1/1/0", ifc.ret_evt, ifc.ret_hit, ifc.call_evt); end
        vec++; if (ifc.ras_count !== 4'd0) begin errs++; $display("FAIL ret_count got %0d exp 0", ifc.ras_count); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] tgt;
        int exp_cnt;
        for (int i = 0; i < DEPTH + 1; i++) begin
            apply(0, 2'd1, 0, 32'h40, 32'h0, 5'd1, 5'd3);
            exp_cnt = (i + 1 > DEPTH) ? DEPTH : i + 1;
            vec++; if (ifc.ras_count !== 4'(exp_cnt)) begin errs++; $display("FAIL ovf_push_count got %0d exp %0d", ifc.ras_count, exp_cnt); end
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            tgt = (m_ras.size() > 0) ? m_ras[$] : m_pc + 32'h8;
            apply(0, 2'd2, 0, 32'h0, tgt, 5'd0, 5'd1);
            exp_cnt = (i < DEPTH) ? DEPTH - 1 - i : 0;
            vec++; if (ifc.ras_count !== 4'(exp_cnt)) begin errs++; $display("FAIL ovf_pop_count got %0d exp %0d", ifc.ras_count, exp_cnt); end
            vec++; if (ifc.ret_evt !== 1'b1 || ifc.evt_target !== tgt) begin
                errs++; $display("FAIL ovf_ret_evt got %b/%h exp 1/%h", ifc.ret_evt, ifc.evt_target, tgt); end
            if (i < DEPTH) begin
                vec++; if (ifc.ret_hit !== 1'b1 || ifc.ras_underflow !== 1'b0) begin
                    errs++; $display("FAIL ovf_hit got hit=%b under=%b exp 1/0", ifc.ret_hit, ifc.ras_underflow); end
            end else begin
                vec++; if (ifc.ret_hit !== 1'b0 || ifc.ras_underflow !== 1'b1) begin
                    errs++; $display("FAIL ovf_underflow got hit=%b under=%b exp 0/1", ifc.ret_hit, ifc.ras_underflow); end
            end
        end
    endtask

    task automatic test_branch_misalign();
        logic [31:0] p0;
        p0 = m_pc;
        apply(0, 2'd3, 0, 32'h20, 32'h0, 5'd0, 5'd0);
        vec++; if (ifc.pc !== p0 + 32'h4) begin errs++; $display("FAIL br_nt got %h exp %h", ifc.pc, p0 + 32'h4); end
        apply(0, 2'd3, 1, 32'h20, 32'h0, 5'd0, 5'd0);
        vec++; if (ifc.pc !== p0 + 32'h24) begin errs++; $display("FAIL br_t got %h exp %h", ifc.pc, p0 + 32'h24); end
        p0 = ifc.pc;
        apply(0, 2'd1, 0, 32'h6, 32'h0, 5'd1, 5'd0);
        vec++; if (ifc.pc !== p0) begin errs++; $display("FAIL mis_pc got %h exp %h", ifc.pc, p0); end
        vec++; if (ifc.misalign !== 1'b1 || ifc.misalign_addr !== p0 + 32'h6) begin
            errs++; $display("FAIL mis_trap got %b/%h exp 1/%h", ifc.misalign, ifc.misalign_addr, p0 + 32'h6); end
        vec++; if (ifc.call_evt !== 1'b0 || ifc.ras_count !== 4'(m_ras.size())) begin
            errs++; $display("FAIL mis_ras got call=%b cnt=%0d exp 0/%0d", ifc.call_evt, ifc.ras_count, m_ras.size()); end
        apply(0, 2'd0, 0, 32'h0, 32'h0, 5'd0, 5'd0);
        vec++; if (ifc.misalign !== 1'b0 || ifc.pc !== p0 + 32'h4) begin
            errs++; $display("FAIL mis_clear got %b/%h exp 0/%h", ifc.misalign, ifc.pc, p0 + 32'h4); end
    endtask

    task automatic test_stall_reset();
        logic [31:0] p0;
        int c0;
        p0 = m_pc;
        c0 = m_ras.size();
        for (int i = 0; i < 3; i++) begin
            apply(1, 2'd1, 0, 32'h80, 32'h0, 5'd1, 5'd0);
            vec++; if (ifc.pc !== p0 || ifc.call_evt !== 1'b0 || ifc.ras_count !== 4'(c0)) begin
                errs++; $display("FAIL stall_hold got pc=%h call=%b cnt=%0d exp %h/0/%0d", ifc.pc, ifc.call_evt, ifc.ras_count, p0, c0); end
        end
        apply(0, 2'd1, 0, 32'h80, 32'h0, 5'd1, 5'd0);
        vec++; if (ifc.pc !== p0 + 32'h80 || ifc.call_evt !== 1'b1 || ifc.ras_count !== 4'(c0 + 1)) begin
            errs++; $display("FAIL stall_release got pc=%h call=%b cnt=%0d exp %h/1/%0d", ifc.pc, ifc.call_evt, ifc.ras_count, p0 + 32'h80, c0 + 1); end
        apply(0, 2'd0, 0, 32'h0, 32'h0, 5'd0, 5'd0);
        vec++; if (ifc.pc !== p0 + 32'h84 || ifc.call_evt !== 1'b0) begin
            errs++; $display("FAIL stall_once got pc=%h call=%b exp %h/0", ifc.pc, ifc.call_evt, p0 + 32'h84); end
        rst = 1;
        ifc.stall = 0; ifc.jump = 2'd1; ifc.imm = 32'h40; ifc.rd = 5'd1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        vec++; if (ifc.pc !== 32'h8000_0000 || ifc.ras_count !== 4'd0 || ifc.call_evt !== 1'b0) begin
            errs++; $display("FAIL mid_reset got pc=%h cnt=%0d call=%b exp 80000000/0/0", ifc.pc, ifc.ras_count, ifc.call_evt); end
    endtask

    task automatic test_random();
        logic        s, bt;
        logic [1:0]  j;
        logic [31:0] im, alu;
        logic [4:0]  d, r1;
        int          k;
        for (int n = 0; n < 400; n++) begin
            s  = ($urandom_range(0, 9) == 0);
            j  = 2'($urandom_range(0, 3));
            bt = 1'($urandom_range(0, 1));
            im = {24'd0, 6'($urandom_range(0, 63)), 2'b00} - 32'd128;
            if ($urandom_range(0, 7) == 0) im[1:0] = 2'($urandom_range(1, 3));
            k  = $urandom_range(0, 3);
            d  = (k == 0) ? 5'd0 : (k == 1) ? 5'd1 : 5'($urandom);
            r1 = ($urandom_range(0, 1) == 1) ? 5'd1 : 5'($urandom);
            if (m_ras.size() > 0 && $urandom_range(0, 2) != 0) alu = m_ras[$];
            else alu = m_pc + {25'd0, 5'($urandom_range(0, 31)), 2'b00};
            alu[0] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) alu[1] = 1'b1;
            apply(s, j, bt, im, alu, d, r1);
            vec++; if (ifc.pc !== m_pc) begin errs++; $display("FAIL rnd_pc n=%0d got %h exp %h", n, ifc.pc, m_pc); end
            vec++; if (ifc.ras_count !== 4'(m_ras.size())) begin errs++; $display("FAIL rnd_count n=%0d got %0d exp %0d", n, ifc.ras_count, m_ras.size()); end
            vec++; if ({ifc.call_evt, ifc.ret_evt, ifc.misalign} !== {e_call, e_ret, e_misalign}) begin
                errs++; $display("FAIL rnd_pulses n=%0d got %b exp %b", n, {ifc.call_evt, ifc.ret_evt, ifc.misalign}, {e_call, e_ret, e_misalign}); end
            if (e_misalign) begin
                vec++; if (ifc.misalign_addr !== e_misaddr) begin errs++; $display("FAIL rnd_misaddr n=%0d got %h exp %h", n, ifc.misalign_addr, e_misaddr); end
            end
            if (e_call || e_ret) begin
                vec++; if (ifc.evt_pc !== e_evt_pc || ifc.evt_target !== e_evt_tgt) begin
                    errs++; $display("FAIL rnd_trace n=%0d got %h/%h exp %h/%h", n, ifc.evt_pc, ifc.evt_target, e_evt_pc, e_evt_tgt); end
            end
            if (e_ret) begin
                vec++; if (ifc.ret_hit !== e_hit || ifc.ras_underflow !== e_under) begin
                    errs++; $display("FAIL rnd_ret n=%0d got hit=%b under=%b exp %b/%b", n, ifc.ret_hit, ifc.ras_underflow, e_hit, e_under); end
            end
        end
    endtask

    initial begin
        ifc.stall = 0; ifc.jump = 0; ifc.br_taken = 0; ifc.imm = 0;
        ifc.alu_result = 0; ifc.rd = 0; ifc.rs1 = 0;
        test_reset();
        test_seq();
        test_call_ret();
        test_ras_overflow();
        test_branch_misalign();
        test_stall_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
